// File: rtl/p405s_icu_fill_seq.sv
// p405s_icu_fill_seq
// Instruction-cache line fill sequencer. Accepts a miss, issues one
// critical-word-first 8-word PLB line read, forwards each returned word
// to the ICU data register with one cycle of latency, and reports a
// clean completion or a bus error. A flush (ABORT) lets the bus read
// drain silently while suppressing all further forwarding.

module p405s_icu_fill_seq (
    input  logic        CB,
    input  logic        RST,
    input  logic        MISS_REQ,
    input  logic [0:29] MISS_ADDR,
    input  logic        ABORT,
    output logic        PLB_REQ,
    output logic [0:29] PLB_ADDR,
    input  logic        PLB_ADDR_ACK,
    input  logic        PLB_RD_ACK,
    input  logic [0:31] PLB_RD_DATA,
    input  logic        PLB_ERR,
    output logic [0:31] FILL_D,
    output logic        FILL_E1,
    output logic [0:2]  FILL_WORD,
    output logic        FILL_CRIT,
    output logic        FILL_DONE,
    output logic        FILL_ERR,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Line word pointer advance; the line is 8 words so it wraps 7 -> 0.
    function automatic logic [2:0] next_word(input logic [2:0] w);
        return w + 3'd1;
    endfunction

    // Registered state and outputs
    state_t      r_state;
    logic [0:29] r_addr;
    logic [2:0]  r_ptr;
    logic [3:0]  r_cnt;
    logic        r_abort;
    logic        r_plb_req;
    logic [0:31] r_fill_d;
    logic        r_fill_e1;
    logic [2:0]  r_fill_word;
    logic        r_fill_crit;
    logic        r_fill_done;
    logic        r_fill_err;
    logic        r_busy;

    // Per-cycle decode
    logic        w_in_bus;
    logic        w_abort_eff;
    logic        w_err;
    logic        w_rd_acc;
    logic        w_last;
    logic        w_fwd;

    // Qualify bus responses against the current state and fold a
    // coincident ABORT into the sticky flag so it already affects the
    // word arriving in the same cycle.
    always_comb begin
        w_in_bus    = (r_state == S_ADDR) || (r_state == S_DATA);
        w_abort_eff = r_abort | (w_in_bus & ABORT);
        w_err       = w_in_bus & PLB_ERR;
        // A read ack is only meaningful in DATA, and an error in the same
        // cycle discards it.
        w_rd_acc    = (r_state == S_DATA) & PLB_RD_ACK & ~PLB_ERR;
        w_last      = w_rd_acc & (r_cnt == 4'd7);
        w_fwd       = w_rd_acc & ~w_abort_eff;
    end

    // Fill sequencer: state, word bookkeeping and all registered outputs.
    always_ff @(posedge CB) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_addr      <= 30'd0;
            r_ptr       <= 3'd0;
            r_cnt       <= 4'd0;
            r_abort     <= 1'b0;
            r_plb_req   <= 1'b0;
            r_fill_d    <= 32'd0;
            r_fill_e1   <= 1'b0;
            r_fill_word <= 3'd0;
            r_fill_crit <= 1'b0;
            r_fill_done <= 1'b0;
            r_fill_err  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_fill_e1   <= 1'b0;
            r_fill_crit <= 1'b0;
            r_fill_done <= 1'b0;
            r_fill_err  <= 1'b0;

            // Every accepted word is counted, even while draining after
            // an abort; only forwarded words touch the data register so
            // FILL_D keeps its last forwarded value otherwise.
            if (w_rd_acc) begin
                r_ptr <= next_word(r_ptr);
                r_cnt <= r_cnt + 4'd1;
                if (w_fwd) begin
                    r_fill_d    <= PLB_RD_DATA;
                    r_fill_word <= r_ptr;
                    r_fill_e1   <= 1'b1;
                    r_fill_crit <= (r_cnt == 4'd0);
                end else begin
                    r_fill_d    <= r_fill_d;
                    r_fill_word <= r_fill_word;
                end
            end else begin
                r_ptr <= r_ptr;
                r_cnt <= r_cnt;
            end

            case (r_state)
                S_IDLE: begin
                    if (MISS_REQ) begin
                        r_addr    <= MISS_ADDR;
                        r_ptr     <= MISS_ADDR[27:29];
                        r_cnt     <= 4'd0;
                        r_abort   <= 1'b0;
                        r_plb_req <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_ADDR;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end

                S_ADDR: begin
                    r_abort <= w_abort_eff;
                    if (w_err) begin
                        r_plb_req  <= 1'b0;
                        r_fill_err <= ~w_abort_eff;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (PLB_ADDR_ACK) begin
                        r_plb_req  <= 1'b0;
                        r_state    <= S_DATA;
                    end else begin
                        r_state    <= S_ADDR;
                    end
                end

                S_DATA: begin
                    r_abort <= w_abort_eff;
                    if (w_err) begin
                        r_fill_err <= ~w_abort_eff;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_last) begin
                        // An aborted fill has nothing to report, so the
                        // drain ends straight in IDLE instead of DONE.
                        if (w_abort_eff) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_fill_done <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end else begin
                        r_state <= S_DATA;
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_plb_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign PLB_REQ   = r_plb_req;
    assign PLB_ADDR  = r_addr;
    assign FILL_D    = r_fill_d;
    assign FILL_E1   = r_fill_e1;
    assign FILL_WORD = r_fill_word;
    assign FILL_CRIT = r_fill_crit;
    assign FILL_DONE = r_fill_done;
    assign FILL_ERR  = r_fill_err;
    assign BUSY      = r_busy;

endmodule
